// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master data bus arbiter: access lengths, FSM states,
// grant encodings and the alignment rule for load/store commands.
package bus_arbiter_pkg;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } arb_state_t;

  // Length code 11 is never legal; halves need even, words need 4-byte aligned addresses.
  function automatic logic ls_misaligned(input logic [1:0] len, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (len)
      LEN_BYTE: bad = 1'b0;
      LEN_HALF: bad = addr_lo[0];
      LEN_WORD: bad = (addr_lo != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins outright, under contention the
// master that was not granted last time wins.
module rr_arbiter2
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    grant = GRANT_IF;
    valid = |req;
    if (req[0] && req[1]) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = GRANT_LS;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the SoC data bus between instruction fetch (read-only) and the load/store unit:
// round-robin grant, one access at a time, fixed wait states, one-cycle ack per master.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_rw,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        bus_rw,
  output logic [1:0]  bus_len,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_write,
  input  logic [31:0] bus_read,
  input  logic        bus_exception
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t       state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             last_grant_reg;
  logic             cmd_master_reg;

  logic        arb_grant;
  logic        arb_valid;
  logic        sel_rw;
  logic [1:0]  sel_len;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;

  rr_arbiter2 u_rr (
    .req        ({ls_req, if_req}),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  // Command of the master the arbiter would grant this cycle; fetches are always word reads.
  always_comb begin
    sel_rw    = 1'b0;
    sel_len   = LEN_WORD;
    sel_addr  = if_addr;
    sel_wdata = 32'd0;
    sel_err   = (if_addr[1:0] != 2'b00);
    if (arb_grant == GRANT_LS) begin
      sel_rw    = ls_rw;
      sel_len   = ls_len;
      sel_addr  = ls_addr;
      sel_wdata = ls_wdata;
      sel_err   = ls_misaligned(ls_len, ls_addr[1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      wait_cnt_reg   <= '0;
      last_grant_reg <= GRANT_LS;
      cmd_master_reg <= GRANT_IF;
      if_ack         <= 1'b0;
      if_rdata       <= 32'd0;
      if_err         <= 1'b0;
      ls_ack         <= 1'b0;
      ls_rdata       <= 32'd0;
      ls_err         <= 1'b0;
      bus_rw         <= 1'b0;
      bus_len        <= 2'b00;
      bus_addr       <= 32'd0;
      bus_write      <= 32'd0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (arb_valid) begin
            last_grant_reg <= arb_grant;
            cmd_master_reg <= arb_grant;
            if (sel_err) begin
              // Rejected commands never reach the bus; answer straight away.
              state_reg <= ST_RESP;
              if (arb_grant == GRANT_IF) begin
                if_ack <= 1'b1;
                if_err <= 1'b1;
              end else begin
                ls_ack <= 1'b1;
                ls_err <= 1'b1;
              end
            end else begin
              state_reg    <= ST_ACCESS;
              wait_cnt_reg <= '0;
              bus_rw       <= sel_rw;
              bus_len      <= sel_len;
              bus_addr     <= sel_addr;
              bus_write    <= sel_wdata;
            end
          end
        end

        ST_ACCESS: begin
          if (wait_cnt_reg == CNT_LAST) begin
            state_reg <= ST_RESP;
            bus_rw    <= 1'b0;
            bus_len   <= 2'b00;
            bus_addr  <= 32'd0;
            bus_write <= 32'd0;
            if (cmd_master_reg == GRANT_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= bus_read;
              if_err   <= bus_exception;
            end else begin
              ls_ack   <= 1'b1;
              ls_rdata <= bus_read;
              ls_err   <= bus_exception;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        ST_RESP: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Two arbiters (one and three wait states) driven by directed and random request rounds;
// every cycle is compared against a transaction-level schedule built from the arbitration rules.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam logic [31:0] LEDS = 32'h0000_2000;

  typedef struct {
    logic        rw;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic        if_req   [2];
  logic [31:0] if_addr  [2];
  logic        if_ack   [2];
  logic [31:0] if_rdata [2];
  logic        if_err   [2];
  logic        ls_req   [2];
  logic        ls_rw    [2];
  logic [1:0]  ls_len   [2];
  logic [31:0] ls_addr  [2];
  logic [31:0] ls_wdata [2];
  logic        ls_ack   [2];
  logic [31:0] ls_rdata [2];
  logic        ls_err   [2];
  logic        bus_rw   [2];
  logic [1:0]  bus_len  [2];
  logic [31:0] bus_addr [2];
  logic [31:0] bus_write[2];
  logic [31:0] bus_read [2];
  logic        bus_exception[2];

  logic        rd_auto;
  logic [31:0] rd_manual;
  logic        exc_auto;
  logic        exc_last;
  logic        exc_manual;

  int  n_tests;
  int  n_fail;
  int  cur_d;
  bit  last_g [2];

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic exc_fn(input logic [31:0] a);
    return (a[11:8] == 4'hE);
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Legal LS commands: byte anywhere, half on even, word on multiple of four.
  function automatic bit ls_bad(input logic [1:0] len, input logic [31:0] a);
    if (len == 2'b00) return 1'b0;
    if (len == 2'b01) return a[0];
    if (len == 2'b10) return (a[1:0] != 2'b00);
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign bus_read[gi]      = rd_auto ? rd_fn(bus_addr[gi]) : rd_manual;
    assign bus_exception[gi] = exc_auto ? exc_fn(bus_addr[gi]) : exc_manual;

    bus_arbiter #(.WAIT_CYCLES((gi == 0) ? 1 : 3)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .if_req        (if_req[gi]),
      .if_addr       (if_addr[gi]),
      .if_ack        (if_ack[gi]),
      .if_rdata      (if_rdata[gi]),
      .if_err        (if_err[gi]),
      .ls_req        (ls_req[gi]),
      .ls_rw         (ls_rw[gi]),
      .ls_len        (ls_len[gi]),
      .ls_addr       (ls_addr[gi]),
      .ls_wdata      (ls_wdata[gi]),
      .ls_ack        (ls_ack[gi]),
      .ls_rdata      (ls_rdata[gi]),
      .ls_err        (ls_err[gi]),
      .bus_rw        (bus_rw[gi]),
      .bus_len       (bus_len[gi]),
      .bus_addr      (bus_addr[gi]),
      .bus_write     (bus_write[gi]),
      .bus_read      (bus_read[gi]),
      .bus_exception (bus_exception[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d) @%0t: got %h expected %h", tag, cur_d, $time, got, exp);
    end
  endtask

  // One request round: reqs raised together, model schedules grants from last_g and
  // fixed latencies, then every cycle up to the idle cycle after the last ack is checked.
  task automatic run_round(input int d, input bit use_if, input bit use_ls,
                           input logic [31:0] ia, input cmd_t lc);
    int w;
    int start;
    int end_c;
    int act;
    int m;
    bit first;
    bit srv [2];
    bit mis [2];
    int s [2];
    int a [2];
    logic [31:0] maddr [2];
    logic [31:0] e_val;
    cur_d = d;
    w = wait_of(d);
    srv[0] = 1'b0; srv[1] = 1'b0;
    s[0] = 0; s[1] = 0; a[0] = -10; a[1] = -10;
    maddr[0] = ia;
    maddr[1] = lc.addr;
    mis[0] = (ia[1:0] != 2'b00);
    mis[1] = ls_bad(lc.len, lc.addr);
    first = (use_if && use_ls) ? !last_g[d] : use_ls;
    start = 0;
    end_c = 1;
    for (int k = 0; k < 2; k++) begin
      m = (k == 0) ? int'(first) : int'(!first);
      if ((m == 0 && use_if) || (m == 1 && use_ls)) begin
        srv[m] = 1'b1;
        s[m] = start;
        a[m] = start + (mis[m] ? 0 : w);
        end_c = a[m] + 1;
        start = a[m] + 2;
        last_g[d] = m[0];
      end
    end

    if_req[d]   = use_if;
    if_addr[d]  = ia;
    ls_req[d]   = use_ls;
    ls_rw[d]    = lc.rw;
    ls_len[d]   = lc.len;
    ls_addr[d]  = lc.addr;
    ls_wdata[d] = lc.wdata;

    for (int c = 0; c <= end_c; c++) begin
      @(posedge clk);
      @(negedge clk);
      act = -1;
      for (int k = 0; k < 2; k++)
        if (srv[k] && !mis[k] && c >= s[k] && c < s[k] + w) act = k;
      check_val("if_ack", 32'(if_ack[d]), 32'(srv[0] && c == a[0]));
      check_val("ls_ack", 32'(ls_ack[d]), 32'(srv[1] && c == a[1]));
      check_val("bus_rw",    32'(bus_rw[d]),  (act == 1) ? 32'(lc.rw) : 32'd0);
      check_val("bus_len",   32'(bus_len[d]), (act == 1) ? 32'(lc.len) : (act == 0) ? 32'd2 : 32'd0);
      check_val("bus_addr",  bus_addr[d],  (act >= 0) ? maddr[act] : 32'd0);
      check_val("bus_write", bus_write[d], (act == 1) ? lc.wdata : 32'd0);
      for (int k = 0; k < 2; k++) begin
        if (srv[k] && c == a[k]) begin
          e_val = mis[k] ? 32'd1 : (exc_auto ? 32'(exc_fn(maddr[k])) : 32'(exc_last));
          if (k == 0) begin
            check_val("if_err", 32'(if_err[d]), e_val);
            if (!mis[k]) check_val("if_rdata", if_rdata[d], rd_auto ? rd_fn(maddr[k]) : rd_manual);
            if_req[d] = 1'b0;
          end else begin
            check_val("ls_err", 32'(ls_err[d]), e_val);
            if (!mis[k]) check_val("ls_rdata", ls_rdata[d], rd_auto ? rd_fn(maddr[k]) : rd_manual);
            ls_req[d] = 1'b0;
          end
        end
      end
      exc_manual = 1'b0;
      for (int k = 0; k < 2; k++)
        if (exc_last && srv[k] && !mis[k] && c == s[k] + w - 1) exc_manual = 1'b1;
    end
    if_req[d] = 1'b0;
    ls_req[d] = 1'b0;
  endtask

  initial begin
    cmd_t lc;
    logic [31:0] ia;
    int sel;
    n_tests = 0;
    n_fail  = 0;
    cur_d   = 0;
    rst = 1'b1;
    rd_auto = 1'b1; rd_manual = 32'd0;
    exc_auto = 1'b1; exc_last = 1'b0; exc_manual = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 1'b0; if_addr[d] = 32'd0;
      ls_req[d] = 1'b0; ls_rw[d] = 1'b0; ls_len[d] = 2'b00;
      ls_addr[d] = 32'd0; ls_wdata[d] = 32'd0;
      last_g[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cur_d = d;
      check_val("rst_if_ack", 32'(if_ack[d]), 32'd0);
      check_val("rst_ls_ack", 32'(ls_ack[d]), 32'd0);
      check_val("rst_bus_rw", 32'(bus_rw[d]), 32'd0);
      check_val("rst_bus_addr", bus_addr[d], 32'd0);
      check_val("rst_if_rdata", if_rdata[d], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // IF fetch from 0x100 returning a fixed word
    rd_auto = 1'b0; rd_manual = 32'hDEAD_BEEF;
    lc = '{rw: 1'b0, len: 2'b10, addr: 32'h0, wdata: 32'h0};
    run_round(0, 1'b1, 1'b0, 32'h0000_0100, lc);
    rd_auto = 1'b1;

    // misaligned half read never touches the bus
    lc = '{rw: 1'b0, len: 2'b01, addr: 32'h0000_0201, wdata: 32'h0};
    run_round(0, 1'b0, 1'b1, 32'h0, lc);

    // word write to the LED register on both wait-state settings
    lc = '{rw: 1'b1, len: 2'b10, addr: LEDS, wdata: 32'h0000_005A};
    run_round(0, 1'b0, 1'b1, 32'h0, lc);
    run_round(1, 1'b0, 1'b1, 32'h0, lc);

    // contention: strict alternation across eight accesses
    for (int r = 0; r < 4; r++) begin
      lc = '{rw: 1'($urandom), len: 2'b10, addr: {$urandom_range(0, 32'hFFFF), 2'b00}, wdata: $urandom};
      run_round(0, 1'b1, 1'b1, {30'($urandom), 2'b00}, lc);
    end

    // bus exception on the final of three wait cycles
    exc_auto = 1'b0; exc_last = 1'b1;
    lc = '{rw: 1'b0, len: 2'b10, addr: 32'h0000_0400, wdata: 32'h0};
    run_round(1, 1'b0, 1'b1, 32'h0, lc);
    exc_auto = 1'b1; exc_last = 1'b0; exc_manual = 1'b0;

    // random rounds on both instances
    for (int r = 0; r < 60; r++) begin
      sel = $urandom_range(1, 3);
      ia = $urandom;
      if ($urandom_range(0, 3) != 0) ia[1:0] = 2'b00;
      lc.rw    = 1'($urandom);
      lc.len   = 2'($urandom_range(0, 3));
      lc.addr  = $urandom;
      lc.wdata = $urandom;
      if ($urandom_range(0, 3) != 0) lc.addr[1:0] = 2'b00;
      run_round(r % 2, sel[0], sel[1], ia, lc);
    end

    // reset in the middle of an LS write: bus clears at once and no ack follows
    cur_d = 1;
    ls_req[1] = 1'b1; ls_rw[1] = 1'b1; ls_len[1] = 2'b10;
    ls_addr[1] = LEDS; ls_wdata[1] = 32'h0000_005A;
    @(posedge clk);
    @(negedge clk);
    check_val("pre_rst_bus_rw", 32'(bus_rw[1]), 32'd1);
    rst = 1'b1;
    #1;
    check_val("async_rst_bus_rw", 32'(bus_rw[1]), 32'd0);
    check_val("async_rst_bus_addr", bus_addr[1], 32'd0);
    check_val("async_rst_bus_write", bus_write[1], 32'd0);
    ls_req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_g[0] = 1'b1;
    last_g[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("no_ack_after_rst", 32'(ls_ack[1]), 32'd0);
    end
    lc = '{rw: 1'b0, len: 2'b00, addr: 32'h0000_0013, wdata: 32'h0};
    run_round(1, 1'b1, 1'b1, 32'h0000_0040, lc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
